// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one 32:1 register read mux among NUM_REQ requesters,
// with a 1-entry tagged response register. Optional macro: ZERO_REG_EN (address 31 reads as zero).
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 64
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]           mux_sel,
  input  logic [DATA_W-1:0]           mux_data,
  output logic                        rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]           rsp_data,
  input  logic                        rsp_ready
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NUM_REQ_W = (ID_W+1)'(NUM_REQ);

  // Handshake: a request is accepted when req_valid[i] & req_ready[i]; the response
  // leaves when rsp_valid & rsp_ready, and a new grant may refill the slot in that same cycle.
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic              slot_free;
  logic              grant_any;
  logic              grant;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand;
  logic [ID_W:0]     next_ptr;
  logic [ADDR_W-1:0] grant_addr;
  logic [DATA_W-1:0] read_data;

  // Walk offsets from the highest down so the one closest to rr_ptr_q wins last.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (req_valid[cand[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[ID_W-1:0];
      end
    end
  end

  assign slot_free  = !rsp_valid_q || rsp_ready;
  assign grant      = grant_any && slot_free && reset_n;
  assign grant_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign req_ready  = grant ? (NUM_REQ'(1) << grant_idx) : '0;
  assign mux_sel    = grant ? grant_addr : '0;

`ifdef ZERO_REG_EN
  assign read_data = (grant_addr == '1) ? '0 : mux_data;
`else
  assign read_data = mux_data;
`endif

  always_comb begin
    next_ptr = {1'b0, grant_idx} + 1'b1;
    if (next_ptr == NUM_REQ_W) next_ptr = '0;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_data_d  = read_data;
      rr_ptr_d    = next_ptr[ID_W-1:0];
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
